// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer: self-test controller for one combinational gate.
// Walks every input vector 0 .. 2**IN_W-1, holds each for SETTLE+1 cycles,
// samples gate_y on the last hold cycle and compares it with TT[vector].
// Reports pass, mismatch count and first failing vector.
// Optional build macro: STOP_ON_FAIL_EN -- end the run at the first mismatch.
module gate_test_sequencer #(
   parameter int                  IN_W   = 2,
   parameter int                  SETTLE = 2,
   parameter logic [2**IN_W-1:0]  TT     = 4'b0111
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [IN_W-1:0]   vec_out,
   input  logic              gate_y,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [IN_W:0]     err_count,
   output logic [IN_W-1:0]   fail_vec
);

   // Hold counter only needs to reach SETTLE; keep at least one bit.
   localparam int               HOLD_W    = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SETTLE);
   localparam logic [IN_W-1:0]   VEC_LAST  = {IN_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t             state_q,  state_d;
   logic [IN_W-1:0]    vec_q,    vec_d;
   logic [HOLD_W-1:0]  hold_q,   hold_d;
   logic               busy_q,   busy_d;
   logic               done_q,   done_d;
   logic               pass_q,   pass_d;
   logic [IN_W:0]      err_q,    err_d;
   logic [IN_W-1:0]    fail_q,   fail_d;

   logic               mismatch;
   logic               last_vec;
   logic [IN_W:0]      err_next;

   // Next-state and next-output logic for the sequencer FSM.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      state_d  = state_q;
      vec_d    = vec_q;
      hold_d   = hold_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      pass_d   = pass_q;
      err_d    = err_q;
      fail_d   = fail_q;
      mismatch = 1'b0;
      last_vec = 1'b0;
      err_next = err_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               vec_d   = '0;
               hold_d  = '0;
               err_d   = '0;
               fail_d  = '0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end

         RUN: begin
            if (hold_q == HOLD_LAST) begin
               // Sample edge for the current vector.
               mismatch = (gate_y != TT[vec_q]);
               err_next = err_q + {{IN_W{1'b0}}, mismatch};
               err_d    = err_next;
               if (mismatch && (err_q == '0)) begin
                  fail_d = vec_q;
               end
`ifdef STOP_ON_FAIL_EN
               last_vec = (vec_q == VEC_LAST) || mismatch;
`else
               last_vec = (vec_q == VEC_LAST);
`endif
               if (last_vec) begin
                  state_d = FIN;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_next == '0);
                  vec_d   = '0;
                  hold_d  = '0;
               end else begin
                  vec_d  = vec_q + IN_W'(1);
                  hold_d = '0;
               end
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end

         FIN: begin
            // done is already high for this single cycle; start is ignored here.
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs; asynchronous reset clears everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         vec_q   <= '0;
         hold_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fail_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         state_q <= state_d;
         vec_q   <= vec_d;
         hold_q  <= hold_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
      end
   end

   assign vec_out   = vec_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb_gate_test_sequencer: directed bench for gate_test_sequencer with
// default parameters (IN_W=2, SETTLE=2, TT=NAND). A behavioural gate model
// can be switched between a good NAND and several faulty variants.
module tb_gate_test_sequencer;

   localparam int IN_W   = 2;
   localparam int SETTLE = 2;
`ifdef STOP_ON_FAIL_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   logic            clk;
   logic            rst;
   logic            start;
   logic [IN_W-1:0] vec_out;
   logic            gate_y;
   logic            busy;
   logic            done;
   logic            pass;
   logic [IN_W:0]   err_count;
   logic [IN_W-1:0] fail_vec;

   // Gate model select: 0 good NAND, 1 AND, 2 NAND stuck-1 on vector 3, 3 NAND inverted on vector 1.
   int mode;

   int errors = 0;
   int checks = 0;

   gate_test_sequencer #(
      .IN_W   (IN_W),
      .SETTLE (SETTLE),
      .TT     (4'b0111)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .vec_out   (vec_out),
      .gate_y    (gate_y),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .fail_vec  (fail_vec)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Gate under test: vec_out[1]=a, vec_out[0]=b.
   always_comb begin
      gate_y = 1'b0;
      case (mode)
         0:       gate_y = ~(vec_out[1] & vec_out[0]);
         1:       gate_y =  (vec_out[1] & vec_out[0]);
         2:       gate_y = (vec_out == 2'd3) ? 1'b1 : ~(vec_out[1] & vec_out[0]);
         3:       gate_y = (vec_out == 2'd1) ? (vec_out[1] & vec_out[0]) : ~(vec_out[1] & vec_out[0]);
         default: gate_y = 1'b0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Pulses start (caller must be at a negedge), then watches the run one
   // negedge at a time. Extra start pulses go out after busy cycles pa and pb.
   task automatic run_and_check(input string tag, input int mode_i, input int pa, input int pb,
                                input int exp_busy, input int exp_err, input int exp_fail,
                                input int exp_pass);
      logic [IN_W-1:0] vseq [0:63];
      int   busy_n   = 0;
      int   done_n   = 0;
      int   seq_bad  = 0;
      bit   seen     = 1'b0;
      bit   finished = 1'b0;
      logic          pass_o  = 1'bx;
      logic [IN_W:0] err_o   = 'x;
      logic [IN_W-1:0] fail_o = 'x;
      logic          pass_a  = 1'bx;
      logic [IN_W:0] err_a   = 'x;
      logic [IN_W-1:0] fail_a = 'x;

      mode  = mode_i;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (busy === 1'b1) begin
            if (busy_n < 64) vseq[busy_n] = vec_out;
            busy_n++;
         end
         if (done === 1'b1) begin
            done_n++;
            seen   = 1'b1;
            pass_o = pass;
            err_o  = err_count;
            fail_o = fail_vec;
         end else if (seen) begin
            finished = 1'b1;
            pass_a   = pass;
            err_a    = err_count;
            fail_a   = fail_vec;
            break;
         end
         start = (busy_n == pa) || (busy_n == pb);
         @(negedge clk);
      end
      start = 1'b0;

      for (int i = 0; i < busy_n && i < 64; i++) begin
         if (vseq[i] !== IN_W'(i / (SETTLE + 1))) seq_bad++;
      end

      check({tag, " finished"},    32'(finished), 32'd1);
      check({tag, " busy_len"},    32'(busy_n),   32'(exp_busy));
      check({tag, " done_pulses"}, 32'(done_n),   32'd1);
      check({tag, " vec_seq_bad"}, 32'(seq_bad),  32'd0);
      check({tag, " pass"},        32'(pass_o),   32'(exp_pass));
      check({tag, " err_count"},   32'(err_o),    32'(exp_err));
      check({tag, " fail_vec"},    32'(fail_o),   32'(exp_fail));
      check({tag, " pass_held"},   32'(pass_a),   32'(exp_pass));
      check({tag, " err_held"},    32'(err_a),    32'(exp_err));
      check({tag, " fail_held"},   32'(fail_a),   32'(exp_fail));
      check({tag, " vec_idle"},    32'(vec_out),  32'd0);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      mode  = 0;

      // Reset state.
      @(negedge clk);
      check("rst vec_out",   32'(vec_out),   32'd0);
      check("rst busy",      32'(busy),      32'd0);
      check("rst done",      32'(done),      32'd0);
      check("rst pass",      32'(pass),      32'd0);
      check("rst err_count", 32'(err_count), 32'd0);
      check("rst fail_vec",  32'(fail_vec),  32'd0);
      rst = 1'b0;
      @(negedge clk);

      // 1. Good NAND: full 12-cycle run, pass.
      run_and_check("t1_nand", 0, 0, 0, 12, 0, 0, 1);

      // 5. Start pulses during busy cycles 2 and 11 are ignored; this run also
      //    begins with a start on the cycle right after the previous done.
      run_and_check("t5_ignore", 0, 2, 11, 12, 0, 0, 1);

      // 2. AND instead of NAND: every vector mismatches.
      run_and_check("t2_and", 1, 0, 0, STOP ? 3 : 12, STOP ? 1 : 4, 0, 0);

      // 3. Stuck-at-1 on vector 3 only.
      run_and_check("t3_stuck", 2, 0, 0, 12, 1, 3, 0);

      // 4. Wrong output on vector 1 only.
      run_and_check("t4_v1", 3, 0, 0, STOP ? 6 : 12, 1, 1, 0);

      // 6. Reset during busy cycle 5 after a failing run left non-zero results.
      mode  = 1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("t6 busy_before_rst", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("t6 rst vec_out",   32'(vec_out),   32'd0);
      check("t6 rst busy",      32'(busy),      32'd0);
      check("t6 rst done",      32'(done),      32'd0);
      check("t6 rst pass",      32'(pass),      32'd0);
      check("t6 rst err_count", 32'(err_count), 32'd0);
      check("t6 rst fail_vec",  32'(fail_vec),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_and_check("t6_after_rst", 0, 0, 0, 12, 0, 0, 1);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
